// File: rtl/seg_argmax.sv
// rtl/seg_argmax.sv - per-pixel 4-class argmax with 2-stage pipeline and per-frame class histogram
module seg_argmax #(
  parameter int HEIGHT    = 4,
  parameter int WIDTH     = 4,
  parameter int W_HEIGHT  = 6,
  parameter int W_WIDTH   = 6,
  parameter int INT_BITW  = 5,
  parameter int FRAC_BITW = 8,
  parameter int UNITS     = 4,
  localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
  localparam int V_BITW     = $clog2(W_HEIGHT),
  localparam int H_BITW     = $clog2(W_WIDTH),
  localparam int CNT_BITW   = $clog2(HEIGHT * WIDTH + 1)
) (
  input  logic                         clock,
  input  logic                         n_rst,
  input  logic [0:FIXED_BITW*4-1]      in_pixels,
  input  logic [V_BITW-1:0]            in_vcnt,
  input  logic [H_BITW-1:0]            in_hcnt,
  output logic [1:0]                   out_label,
  output logic signed [FIXED_BITW-1:0] out_score,
  output logic [V_BITW-1:0]            out_vcnt,
  output logic [H_BITW-1:0]            out_hcnt,
  output logic                         hist_valid,
  output logic [CNT_BITW-1:0]          class_count_0,
  output logic [CNT_BITW-1:0]          class_count_1,
  output logic [CNT_BITW-1:0]          class_count_2,
  output logic [CNT_BITW-1:0]          class_count_3
);

  typedef enum logic {S_WAIT_SOF, S_COUNT} state_t;

  logic signed [FIXED_BITW-1:0] sc [4];

  // Stage 1: pairwise winners; the higher index wins only when strictly greater
  logic                         a_sel_d, a_sel_q, b_sel_d, b_sel_q;
  logic signed [FIXED_BITW-1:0] a_score_d, a_score_q, b_score_d, b_score_q;
  logic [V_BITW-1:0]            vcnt1_d, vcnt1_q;
  logic [H_BITW-1:0]            hcnt1_d, hcnt1_q;

  // Stage 2 and histogram
  logic [1:0]                   out_label_d, out_label_q;
  logic signed [FIXED_BITW-1:0] out_score_d, out_score_q;
  logic [V_BITW-1:0]            out_vcnt_d, out_vcnt_q;
  logic [H_BITW-1:0]            out_hcnt_d, out_hcnt_q;
  logic [1:0]                   fill_d, fill_q;
  state_t                       state_d, state_q;
  logic                         hist_valid_d, hist_valid_q;
  logic [CNT_BITW-1:0]          acc_d [UNITS];
  logic [CNT_BITW-1:0]          acc_q [UNITS];
  logic [CNT_BITW-1:0]          cnt_d [UNITS];
  logic [CNT_BITW-1:0]          cnt_q [UNITS];
  logic                         o_sel, sof, active_out, last_out, count_en;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sc[k] = in_pixels[k*FIXED_BITW +: FIXED_BITW];
    end
    a_sel_d   = sc[1] > sc[0];
    a_score_d = a_sel_d ? sc[1] : sc[0];
    b_sel_d   = sc[3] > sc[2];
    b_score_d = b_sel_d ? sc[3] : sc[2];
    vcnt1_d   = in_vcnt;
    hcnt1_d   = in_hcnt;

    o_sel       = b_score_q > a_score_q;
    out_label_d = o_sel ? {1'b1, b_sel_q} : {1'b0, a_sel_q};
    out_score_d = o_sel ? b_score_q : a_score_q;
    out_vcnt_d  = vcnt1_q;
    out_hcnt_d  = hcnt1_q;
    fill_d      = {fill_q[0], 1'b1};
  end

  // fill_q[1] marks that the stage-2 outputs hold a real pixel rather than reset values
  always_comb begin
    state_d      = state_q;
    hist_valid_d = 1'b0;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    active_out   = (int'(out_vcnt_q) < HEIGHT) && (int'(out_hcnt_q) < WIDTH);
    last_out     = (int'(out_vcnt_q) == HEIGHT - 1) && (int'(out_hcnt_q) == WIDTH - 1);
    sof          = fill_q[1] && (out_vcnt_q == '0) && (out_hcnt_q == '0);
    count_en     = (state_q == S_COUNT) || sof;
    if (state_q == S_WAIT_SOF && sof) begin
      state_d = S_COUNT;
    end
    if (count_en && active_out) begin
      acc_d[out_label_q] = acc_q[out_label_q] + CNT_BITW'(1);
      if (last_out) begin
        for (int k = 0; k < UNITS; k++) begin
          cnt_d[k] = acc_d[k];
          acc_d[k] = '0;
        end
        hist_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      a_sel_q      <= 1'b0;
      b_sel_q      <= 1'b0;
      a_score_q    <= '0;
      b_score_q    <= '0;
      vcnt1_q      <= '0;
      hcnt1_q      <= '0;
      out_label_q  <= '0;
      out_score_q  <= '0;
      out_vcnt_q   <= '0;
      out_hcnt_q   <= '0;
      fill_q       <= '0;
      state_q      <= S_WAIT_SOF;
      hist_valid_q <= 1'b0;
      for (int k = 0; k < UNITS; k++) begin
        acc_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      a_sel_q      <= a_sel_d;
      b_sel_q      <= b_sel_d;
      a_score_q    <= a_score_d;
      b_score_q    <= b_score_d;
      vcnt1_q      <= vcnt1_d;
      hcnt1_q      <= hcnt1_d;
      out_label_q  <= out_label_d;
      out_score_q  <= out_score_d;
      out_vcnt_q   <= out_vcnt_d;
      out_hcnt_q   <= out_hcnt_d;
      fill_q       <= fill_d;
      state_q      <= state_d;
      hist_valid_q <= hist_valid_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_label     = out_label_q;
  assign out_score     = out_score_q;
  assign out_vcnt      = out_vcnt_q;
  assign out_hcnt      = out_hcnt_q;
  assign hist_valid    = hist_valid_q;
  assign class_count_0 = cnt_q[0];
  assign class_count_1 = cnt_q[1];
  assign class_count_2 = cnt_q[2];
  assign class_count_3 = cnt_q[3];

endmodule
